// File: rtl/tick_counter_pkg.sv
// Shared types and helpers for tick_counter: divider sizing, limit values
// and packed-BCD increment/decrement/clamp on a full-width vector.
package tick_counter_pkg;

    localparam int unsigned MAX_DIGITS = 6;
    localparam int unsigned MAX_W      = 4 * MAX_DIGITS;

    typedef struct packed {
        logic             carry;
        logic [MAX_W-1:0] value;
    } bcd_res_t;

    // Returns 0 when the ratio is not a positive integer so the top can flag it.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        if (tick_hz == 0 || (clk_hz % tick_hz) != 0) begin
            return 0;
        end
        return clk_hz / tick_hz;
    endfunction

    function automatic logic [MAX_W-1:0] max_value(input int unsigned digits,
                                                   input int unsigned bcd);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                v[4*i +: 4] = (bcd != 0) ? 4'd9 : 4'hF;
            end
        end
        return v;
    endfunction

    function automatic bcd_res_t bcd_inc(input logic [MAX_W-1:0] v,
                                         input int unsigned digits);
        bcd_res_t r;
        logic     c;
        r.value = v;
        c       = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r.value[4*i +: 4] = 4'd0;
                end else begin
                    r.value[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        r.carry = c;
        return r;
    endfunction

    function automatic bcd_res_t bcd_dec(input logic [MAX_W-1:0] v,
                                         input int unsigned digits);
        bcd_res_t r;
        logic     b;
        r.value = v;
        b       = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r.value[4*i +: 4] = 4'd9;
                end else begin
                    r.value[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        r.carry = b;
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] bcd_clamp(input logic [MAX_W-1:0] v,
                                                   input int unsigned digits);
        logic [MAX_W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dec7seg.sv
// Hex digit to active-low seven-segment pattern; bit 0 = segment a, bit 6 = g.
module dec7seg (
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'b1111111;
        case (i_digit)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/tick_gen.sv
// Prescaler: free-running modulo-DIV phase counter with a registered
// one-cycle tick on the wrap.
module tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned     PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

    logic [PW-1:0] r_pcnt;
    logic          r_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_pcnt == LAST);
            r_pcnt <= (r_pcnt == LAST) ? '0 : r_pcnt + PW'(1);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/tick_counter.sv
// Prescaled display counter: binary or BCD, up/down, loadable, wrap or
// saturate, with per-digit seven-segment outputs.
module tick_counter
    import tick_counter_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_HZ  = 1,
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned BCD      = 0,
    parameter int unsigned SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  limit,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int unsigned  DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned  W   = 4 * DIGITS;
    localparam logic [W-1:0] MAX = W'(max_value(DIGITS, BCD));

    if (DIV == 0) begin : g_bad_div
        $error("tick_counter: CLK_HZ/TICK_HZ must be a positive integer");
    end
    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("tick_counter: DIGITS must be in 1..6");
    end

    logic         w_tick;
    logic         w_step;
    logic [W-1:0] w_next;
    logic         w_limit;
    logic [W-1:0] r_count;
    logic         r_limit;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_step = w_tick & en & ~load;

    // Next count: load beats step; boundary steps wrap or hold and flag limit.
    always_comb begin
        w_next  = r_count;
        w_limit = 1'b0;
        if (load) begin
            w_next = (BCD != 0) ? W'(bcd_clamp(MAX_W'(load_val), DIGITS)) : load_val;
        end else if (w_step) begin
            if (up) begin
                if (r_count == MAX) begin
                    w_limit = 1'b1;
                    w_next  = (SATURATE != 0) ? MAX : '0;
                end else begin
                    w_next = (BCD != 0) ? W'(bcd_inc(MAX_W'(r_count), DIGITS))
                                        : r_count + W'(1);
                end
            end else begin
                if (r_count == '0) begin
                    w_limit = 1'b1;
                    w_next  = (SATURATE != 0) ? '0 : MAX;
                end else begin
                    w_next = (BCD != 0) ? W'(bcd_dec(MAX_W'(r_count), DIGITS))
                                        : r_count - W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_limit <= 1'b0;
        end else begin
            r_count <= w_next;
            r_limit <= w_limit;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_seg
        dec7seg u_dec (
            .i_digit (r_count[4*i +: 4]),
            .o_seg   (hex[7*i +: 7])
        );
    end

    assign count = r_count;
    assign tick  = w_tick;
    assign limit = r_limit;

endmodule

// File: tb/tb_tick_counter.sv
// Directed bench for tick_counter: four instances (binary wrap, BCD,
// saturating, DIV=1) share stimulus; each check targets one instance.
module tb_tick_counter;

    bit         clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;

    logic [7:0]  cnt_a, cnt_b, cnt_c, cnt_d;
    logic        tick_a, tick_b, tick_c, tick_d;
    logic        lim_a, lim_b, lim_c, lim_d;
    logic [13:0] hex_a, hex_b, hex_c, hex_d;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tick_counter #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .BCD(0), .SATURATE(0)) u_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(cnt_a), .tick(tick_a), .limit(lim_a), .hex(hex_a));
    tick_counter #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .BCD(1), .SATURATE(0)) u_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(cnt_b), .tick(tick_b), .limit(lim_b), .hex(hex_b));
    tick_counter #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .BCD(0), .SATURATE(1)) u_c (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(cnt_c), .tick(tick_c), .limit(lim_c), .hex(hex_c));
    tick_counter #(.CLK_HZ(1), .TICK_HZ(1), .DIGITS(2), .BCD(0), .SATURATE(0)) u_d (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(cnt_d), .tick(tick_d), .limit(lim_d), .hex(hex_d));

    typedef struct {
        string      name;
        bit         is_load;
        logic [7:0] val;
        bit         v_en;
        bit         v_up;
        int         dut;
        logic [7:0] exp_cnt;
        bit         exp_lim;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [13:0] seg2(input logic [7:0] v);
        return {seg(v[7:4]), seg(v[3:0])};
    endfunction

    function automatic logic [7:0] get_cnt(input int d);
        case (d) 0: return cnt_a; 1: return cnt_b; 2: return cnt_c; default: return cnt_d; endcase
    endfunction
    function automatic logic get_lim(input int d);
        case (d) 0: return lim_a; 1: return lim_b; 2: return lim_c; default: return lim_d; endcase
    endfunction
    function automatic logic [13:0] get_hex(input int d);
        case (d) 0: return hex_a; 1: return hex_b; 2: return hex_c; default: return hex_d; endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input bit is_load, input logic [7:0] val,
                       input bit v_en, input bit v_up, input int dut,
                       input logic [7:0] exp_cnt, input bit exp_lim);
        vec_t v;
        v.name = name; v.is_load = is_load; v.val = val; v.v_en = v_en; v.v_up = v_up;
        v.dut = dut; v.exp_cnt = exp_cnt; v.exp_lim = exp_lim;
        vecs.push_back(v);
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        while (!tick_a && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!tick_a) chk({name, "_tick_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        if (v.is_load) begin
            load = 1'b1; load_val = v.val;
            @(negedge clk);
            load = 1'b0;
        end else begin
            en = v.v_en; up = v.v_up; load = 1'b0;
            wait_tick(v.name);
            @(negedge clk);
        end
        chk({v.name, "_count"}, 32'(get_cnt(v.dut)), 32'(v.exp_cnt));
        chk({v.name, "_limit"}, 32'(get_lim(v.dut)), 32'(v.exp_lim));
        chk({v.name, "_hex"},   32'(get_hex(v.dut)), 32'(seg2(v.exp_cnt)));
        if (!v.is_load) begin
            @(negedge clk);
            chk({v.name, "_limit_drop"}, 32'(get_lim(v.dut)), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 8'h00;

        add("bcd_load98",   1, 8'h98, 1, 1, 1, 8'h98, 0);
        add("bcd_up99",     0, 8'h00, 1, 1, 1, 8'h99, 0);
        add("bcd_up_wrap",  0, 8'h00, 1, 1, 1, 8'h00, 1);
        add("bcd_dn_wrap",  0, 8'h00, 1, 0, 1, 8'h99, 1);
        add("bcd_clampAF",  1, 8'hAF, 1, 1, 1, 8'h99, 0);
        add("bin_loadAF",   1, 8'hAF, 1, 1, 0, 8'hAF, 0);
        add("bcd_clamp5A",  1, 8'h5A, 1, 1, 1, 8'h59, 0);
        add("bcd_load19",   1, 8'h19, 1, 1, 1, 8'h19, 0);
        add("bcd_carry20",  0, 8'h00, 1, 1, 1, 8'h20, 0);
        add("bcd_load40",   1, 8'h40, 1, 1, 1, 8'h40, 0);
        add("bcd_borrow39", 0, 8'h00, 1, 0, 1, 8'h39, 0);
        add("sat_loadFE",   1, 8'hFE, 1, 1, 2, 8'hFE, 0);
        add("sat_upFF",     0, 8'h00, 1, 1, 2, 8'hFF, 0);
        add("sat_hold1",    0, 8'h00, 1, 1, 2, 8'hFF, 1);
        add("sat_hold2",    0, 8'h00, 1, 1, 2, 8'hFF, 1);
        add("sat_load01",   1, 8'h01, 1, 0, 2, 8'h01, 0);
        add("sat_dn00",     0, 8'h00, 1, 0, 2, 8'h00, 0);
        add("sat_hold0",    0, 8'h00, 1, 0, 2, 8'h00, 1);
        add("bin_loadFF",   1, 8'hFF, 1, 1, 0, 8'hFF, 0);
        add("bin_up_wrap",  0, 8'h00, 1, 1, 0, 8'h00, 1);
        add("bin_dn_wrap",  0, 8'h00, 1, 0, 0, 8'hFF, 1);
        add("bin_dnFE",     0, 8'h00, 1, 0, 0, 8'hFE, 0);
        add("bin_load10",   1, 8'h10, 1, 1, 0, 8'h10, 0);
        add("en0_up",       0, 8'h00, 0, 1, 0, 8'h10, 0);
        add("en0_dn",       0, 8'h00, 0, 0, 0, 8'h10, 0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk("rst_count", 32'(get_cnt(d)), 32'd0);
            chk("rst_limit", 32'(get_lim(d)), 32'd0);
            chk("rst_hex",   32'(get_hex(d)), 32'(seg2(8'h00)));
        end
        chk("rst_tick_a", 32'(tick_a), 32'd0);
        chk("rst_tick_d", 32'(tick_d), 32'd0);

        // Cadence: tick after edges 10/20/30, count follows one edge later
        reset = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            chk($sformatf("cad_tick_k%0d", k), 32'(tick_a), 32'((k % 10) == 0));
            chk($sformatf("cad_cnt_k%0d", k), 32'(cnt_a),
                32'((k >= 11) + (k >= 21) + (k >= 31)));
            chk($sformatf("div1_cnt_k%0d", k), 32'(cnt_d), 32'(k - 1));
            chk($sformatf("div1_tick_k%0d", k), 32'(tick_d), 32'd1);
            if (k == 11 || k == 21 || k == 31)
                chk($sformatf("cad_hex_k%0d", k), 32'(hex_a), 32'(seg2(8'(k / 10))));
        end

        foreach (vecs[i]) run_vec(vecs[i]);

        // Load on a tick cycle beats the step
        en = 1'b1; up = 1'b1;
        wait_tick("prio");
        load = 1'b1; load_val = 8'h42;
        @(negedge clk);
        load = 1'b0;
        chk("prio_count_a", 32'(cnt_a), 32'h42);
        chk("prio_limit_a", 32'(lim_a), 32'd0);
        chk("prio_count_b", 32'(cnt_b), 32'h42);

        // Reset mid-period at pcnt=6
        load = 1'b1; load_val = 8'h37;
        @(negedge clk);
        load = 1'b0; en = 1'b0;
        chk("mid_load37", 32'(cnt_a), 32'h37);
        wait_tick("mid");
        repeat (6) @(negedge clk);
        chk("mid_pre_cnt", 32'(cnt_a), 32'h37);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_cnt",  32'(cnt_a), 32'd0);
        chk("mid_rst_tick", 32'(tick_a), 32'd0);
        chk("mid_rst_lim",  32'(lim_a), 32'd0);
        chk("mid_rst_hex",  32'(hex_a), 32'(seg2(8'h00)));
        reset = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("mid_tick_k%0d", k), 32'(tick_a), 32'(k == 10));
            if (k == 10 || k == 12)
                chk($sformatf("mid_cnt_k%0d", k), 32'(cnt_a), 32'(k == 12));
        end

        // DIV=1 wrap through 0xFF
        load = 1'b1; load_val = 8'hFD;
        @(negedge clk);
        load = 1'b0;
        chk("div1_loadFD", 32'(cnt_d), 32'hFD);
        chk("div1_load_lim", 32'(lim_d), 32'd0);
        for (int s = 1; s <= 4; s++) begin
            logic [7:0] e;
            e = 8'(8'hFD + s);
            @(negedge clk);
            chk($sformatf("div1_cnt_s%0d", s), 32'(cnt_d), 32'(e));
            chk($sformatf("div1_lim_s%0d", s), 32'(lim_d), 32'(s == 3));
            chk($sformatf("div1_tick_s%0d", s), 32'(tick_d), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tick_counter.md
# tick_counter

Parametrised display counter for the board top level. An internal prescaler divides the 50 MHz board clock down to a slow tick, and a configurable counter advances on each tick. The counter is N digits wide, binary or BCD, counts up or down, can be parallel-loaded, and wraps or saturates at its limits. It drives the red LEDs directly and the seven-segment digits through the existing `dec7seg` decoder, and it replaces hand-written divider/counter pairs in lab tops.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency.
- `TICK_HZ`, 1: step rate. `DIV = CLK_HZ/TICK_HZ`, integer, ≥1 (elaboration error otherwise).
- `DIGITS`, 2: number of 4-bit digits. `W = 4*DIGITS`, 1..6.
- `BCD`, 0: 0 = binary modulo 2^W; 1 = decimal, each digit 0..9.
- `SATURATE`, 0: 0 = wrap at limits; 1 = hold at limits.
- `clk`  in  1  system clock (`clock_50` at top level)
- `reset`  in  1  synchronous, active-high reset
- `en`  in  1  step enable, sampled on tick cycles
- `up`  in  1  1 = count up, 0 = count down
- `load`  in  1  parallel load strobe
- `load_val`  in  W  value loaded when `load`=1
- `count`  out  W  registered counter value
- `tick`  out  1  registered one-cycle prescaler pulse
- `limit`  out  1  registered one-cycle pulse: a step crossed or hit a boundary
- `hex`  out  7*DIGITS  segment patterns; digit i on bits [7i+6:7i], active-low per `dec7seg`

## Operation
- `MAX` = 2^W−1 (binary) or 10^DIGITS−1 (BCD).
- Prescaler:
  - Counter `pcnt` runs 0..DIV−1 and wraps.
  - `tick` is registered `(pcnt==DIV−1)`.
  - DIV=1 gives `tick` permanently high after the first post-reset edge.
- `step` = `tick & en & ~load`.
- Priority per edge: `reset` > `load` > `step` > hold.
- Load:
  - `count` ← `load_val`. In BCD mode, any digit >9 is clamped to 9.
  - `limit` stays 0.
  - The prescaler is unaffected.
- Step up:
  - Below MAX: `count`+1. In BCD, the digit carry ripples (e.g. 0x19→0x20, 0x99→0x00 for DIGITS=2).
  - At MAX: wrap to 0, or hold MAX if SATURATE. `limit`=1 in both cases.
- Step down:
  - Above 0: `count`−1. In BCD, a borrow sets the digit to 9.
  - At 0: wrap to MAX, or hold 0 if SATURATE. `limit`=1.
- `up` and `en` are sampled only on the step edge; changing them between ticks has no effect.
- `hex` is combinational from `count` (one `dec7seg` per digit). A binary digit shows 0–F.

## Timing
- Reset values: `pcnt`=0, `tick`=0, `count`=0, `limit`=0. `hex` shows all zeros one combinational delay after reset.
- Tick cadence:
  - Edge k after reset release leaves `pcnt`=k mod DIV.
  - `tick` is high for exactly one cycle after edges DIV, 2·DIV, …, so the period is DIV cycles.
- `count` and `limit` update on the edge that samples `tick`=1, i.e. 1 cycle of latency from `tick`. `limit` is high for that one cycle only.
- A `load` occurring on a tick cycle wins; that step is lost, not deferred.
- Reset mid-period clears the prescaler phase. The next tick comes a full DIV edges later.

## Structure
- Package `tick_counter_pkg`:
  - function `max_value(DIGITS,BCD)`
  - function `bcd_inc`/`bcd_dec` on a W-bit vector returning {value, carry}
  - constant `DIV` computation helper
- Sub-module `tick_gen` (params `DIV`; ports `clk`, `reset`, `tick`) holds the prescaler.
- `dec7seg` is reused unmodified.
- The counter datapath sits in `tick_counter` itself.

## Test plan
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10), DIGITS=2.
- **Cadence:** reset 3 cycles, then en=1, up=1, BCD=0 → `tick` high after edges 10, 20, 30; `count`=1, 2, 3 one cycle after each tick; `hex` digit0 tracks.
- **BCD rollover:** BCD=1, load 0x98, up → steps give 0x99 then 0x00 with `limit`=1 exactly once. Down from 0x00 → 0x99, `limit`=1. Load 0xAF → `count`=0x99.
- **Saturate:** BCD=0, SATURATE=1, load 0xFE, up → 0xFF, then 0xFF held with `limit` pulsing each tick. Down from 0x01 → 0x00, then held.
- **Priority:** `load`=1 with `load_val`=0x42 on a tick cycle with en=1 → `count`=0x42, no increment, `limit`=0. en=0 across ticks → `count` constant.
- **Reset mid-period:** assert `reset` at `pcnt`=6 with `count`=0x37 → all outputs 0 next edge; first tick 10 edges after release.
- **DIV=1** (CLK_HZ=TICK_HZ=1), BCD=0, up → `count` increments every cycle, 0xFF→0x00 with `limit`=1.
